// File: rtl/axi_slave_mem.sv
// AXI4 memory-mapped slave backed by a 2^DEPTH_LOG2-word byte-writable array.
// Independent read and write channels, one outstanding burst per direction.
module axi_slave_mem #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      s_axi_a_AWVALID,
   output logic                      s_axi_a_AWREADY,
   input  logic [ADDR_WIDTH-1:0]     s_axi_a_AWADDR,
   input  logic [ID_WIDTH-1:0]       s_axi_a_AWID,
   input  logic [7:0]                s_axi_a_AWLEN,
   input  logic [1:0]                s_axi_a_AWBURST,
   input  logic                      s_axi_a_WVALID,
   output logic                      s_axi_a_WREADY,
   input  logic [DATA_WIDTH-1:0]     s_axi_a_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_a_WSTRB,
   input  logic                      s_axi_a_WLAST,
   output logic                      s_axi_a_BVALID,
   input  logic                      s_axi_a_BREADY,
   output logic [1:0]                s_axi_a_BRESP,
   output logic [ID_WIDTH-1:0]       s_axi_a_BID,
   input  logic                      s_axi_a_ARVALID,
   output logic                      s_axi_a_ARREADY,
   input  logic [ADDR_WIDTH-1:0]     s_axi_a_ARADDR,
   input  logic [ID_WIDTH-1:0]       s_axi_a_ARID,
   input  logic [7:0]                s_axi_a_ARLEN,
   input  logic [1:0]                s_axi_a_ARBURST,
   output logic                      s_axi_a_RVALID,
   input  logic                      s_axi_a_RREADY,
   output logic [DATA_WIDTH-1:0]     s_axi_a_RDATA,
   output logic                      s_axi_a_RLAST,
   output logic [ID_WIDTH-1:0]       s_axi_a_RID,
   output logic [1:0]                s_axi_a_RRESP
);

   // state   | meaning
   // W_IDLE  | waiting for a write address
   // W_DATA  | accepting write beats
   // W_RESP  | presenting the write response
   // R_IDLE  | waiting for a read address
   // R_DATA  | presenting read beats

   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int BYTE_LOG2 = $clog2(STRB_W);
   localparam int DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_t              w_state_q, w_state_d;
   logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
   logic [7:0]            w_len_q, w_len_d;
   logic [7:0]            w_cnt_q, w_cnt_d;
   logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
   logic [1:0]            w_burst_q, w_burst_d;
   logic                  w_err_q, w_err_d;
   logic                  mem_we;

   r_state_t              r_state_q, r_state_d;
   logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
   logic [7:0]            r_len_q, r_len_d;
   logic [7:0]            r_cnt_q, r_cnt_d;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [1:0]            r_burst_q, r_burst_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   // Holds both address channels closed for the first cycle after reset.
   logic                  rdy_en_q;

   logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;
   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                  unused_addr;

   assign aw_idx = s_axi_a_AWADDR[DEPTH_LOG2+BYTE_LOG2-1:BYTE_LOG2];
   assign ar_idx = s_axi_a_ARADDR[DEPTH_LOG2+BYTE_LOG2-1:BYTE_LOG2];
   assign unused_addr = ^{s_axi_a_AWADDR, s_axi_a_ARADDR};

   assign s_axi_a_AWREADY = rdy_en_q && (w_state_q == W_IDLE);
   assign s_axi_a_WREADY  = (w_state_q == W_DATA);
   assign s_axi_a_BVALID  = (w_state_q == W_RESP);
   assign s_axi_a_BID     = w_id_q;
   assign s_axi_a_BRESP   = (s_axi_a_BVALID && (w_err_q || (w_burst_q != BURST_INCR)))
                            ? RESP_SLVERR : RESP_OKAY;

   assign s_axi_a_ARREADY = rdy_en_q && (r_state_q == R_IDLE);
   assign s_axi_a_RVALID  = (r_state_q == R_DATA);
   assign s_axi_a_RDATA   = rdata_q;
   assign s_axi_a_RID     = r_id_q;
   assign s_axi_a_RLAST   = s_axi_a_RVALID && (r_cnt_q == r_len_q);
   assign s_axi_a_RRESP   = (s_axi_a_RVALID && (r_burst_q != BURST_INCR))
                            ? RESP_SLVERR : RESP_OKAY;

   assign aw_hs = s_axi_a_AWVALID && s_axi_a_AWREADY;
   assign w_hs  = s_axi_a_WVALID  && s_axi_a_WREADY;
   assign b_hs  = s_axi_a_BVALID  && s_axi_a_BREADY;
   assign ar_hs = s_axi_a_ARVALID && s_axi_a_ARREADY;
   assign r_hs  = s_axi_a_RVALID  && s_axi_a_RREADY;

   always_comb begin
      w_state_d = w_state_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_id_d    = w_id_q;
      w_burst_d = w_burst_q;
      w_err_d   = w_err_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               w_idx_d   = aw_idx;
               w_len_d   = s_axi_a_AWLEN;
               w_id_d    = s_axi_a_AWID;
               w_burst_d = s_axi_a_AWBURST;
               w_cnt_d   = 8'd0;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               mem_we  = 1'b1;
               w_idx_d = w_idx_q + DEPTH_LOG2'(1);
               w_cnt_d = w_cnt_q + 8'd1;
               // WLAST must appear on the final beat and nowhere else.
               if (s_axi_a_WLAST != (w_cnt_q == w_len_q)) begin
                  w_err_d = 1'b1;
               end
               if (w_cnt_q == w_len_q) begin
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (b_hs) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Reads sample the array before this edge's write lands: pre-write data wins.
   always_comb begin
      r_state_d = r_state_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_id_d    = r_id_q;
      r_burst_d = r_burst_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rdata_d   = mem[ar_idx];
               r_idx_d   = ar_idx + DEPTH_LOG2'(1);
               r_len_d   = s_axi_a_ARLEN;
               r_id_d    = s_axi_a_ARID;
               r_burst_d = s_axi_a_ARBURST;
               r_cnt_d   = 8'd0;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (r_hs) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  rdata_d = mem[r_idx_q];
                  r_idx_d = r_idx_q + DEPTH_LOG2'(1);
                  r_cnt_d = r_cnt_q + 8'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rdy_en_q  <= 1'b0;
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_id_q    <= '0;
         w_burst_q <= '0;
         w_err_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_id_q    <= '0;
         r_burst_q <= '0;
         rdata_q   <= '0;
      end else begin
         rdy_en_q  <= 1'b1;
         w_state_q <= w_state_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_id_q    <= w_id_d;
         w_burst_q <= w_burst_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_id_q    <= r_id_d;
         r_burst_q <= r_burst_d;
         rdata_q   <= rdata_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge ap_clk) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (s_axi_a_WSTRB[i]) begin
               mem[w_idx_q][8*i +: 8] <= s_axi_a_WDATA[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, back-pressure, error
// responses, index wrap, same-word read/write and mid-burst reset.
module tb_axi_slave_mem;

   logic        ap_clk;
   logic        ap_rst_n;
   logic        awvalid, awready;
   logic [63:0] awaddr;
   logic [0:0]  awid;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [0:0]  bid;
   logic        arvalid, arready;
   logic [63:0] araddr;
   logic [0:0]  arid;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic        rlast;
   logic [0:0]  rid;
   logic [1:0]  rresp;

   int total = 0;
   int bad   = 0;
   logic [31:0] wdat [16];
   logic [31:0] rexp [16];

   axi_slave_mem dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_axi_a_AWVALID(awvalid), .s_axi_a_AWREADY(awready), .s_axi_a_AWADDR(awaddr),
      .s_axi_a_AWID(awid), .s_axi_a_AWLEN(awlen), .s_axi_a_AWBURST(awburst),
      .s_axi_a_WVALID(wvalid), .s_axi_a_WREADY(wready), .s_axi_a_WDATA(wdata),
      .s_axi_a_WSTRB(wstrb), .s_axi_a_WLAST(wlast),
      .s_axi_a_BVALID(bvalid), .s_axi_a_BREADY(bready), .s_axi_a_BRESP(bresp),
      .s_axi_a_BID(bid),
      .s_axi_a_ARVALID(arvalid), .s_axi_a_ARREADY(arready), .s_axi_a_ARADDR(araddr),
      .s_axi_a_ARID(arid), .s_axi_a_ARLEN(arlen), .s_axi_a_ARBURST(arburst),
      .s_axi_a_RVALID(rvalid), .s_axi_a_RREADY(rready), .s_axi_a_RDATA(rdata),
      .s_axi_a_RLAST(rlast), .s_axi_a_RID(rid), .s_axi_a_RRESP(rresp)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [0:0] id,
                           input int wlast_at, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
      int n;
      awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awid = id;
      n = 0;
      while (!awready && n < 50) begin tick; n++; end
      if (n == 50) chk("aw_timeout", 1, 0);
      tick;
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wvalid = 1'b1; wdata = wdat[b]; wstrb = strb; wlast = (b == wlast_at);
         n = 0;
         while (!wready && n < 50) begin tick; n++; end
         if (n == 50) chk("w_timeout", 1, 0);
         tick;
      end
      wvalid = 1'b0; wlast = 1'b0;
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin tick; n++; end
      chk("b_valid", bvalid, 1);
      chk("b_resp", bresp, exp_resp);
      chk("b_id", bid, id);
      tick;
      bready = 1'b0;
      chk("b_once", bvalid, 0);
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [0:0] id,
                          input logic [1:0] exp_resp, input int stall_at);
      int n;
      arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arid = id;
      n = 0;
      while (!arready && n < 50) begin tick; n++; end
      if (n == 50) chk("ar_timeout", 1, 0);
      tick;
      arvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         rready = (b != stall_at);
         n = 0;
         while (!rvalid && n < 20) begin tick; n++; end
         chk("r_lat", n, 0);
         chk("r_data", rdata, rexp[b]);
         chk("r_last", rlast, (b == int'(len)));
         chk("r_id", rid, id);
         chk("r_resp", rresp, exp_resp);
         if (b == stall_at) begin
            repeat (5) tick;
            chk("r_stall_valid", rvalid, 1);
            chk("r_stall_data", rdata, rexp[b]);
            chk("r_stall_last", rlast, (b == int'(len)));
            rready = 1'b1;
         end
         tick;
      end
      rready = 1'b0;
      chk("r_done", rvalid, 0);
   endtask

   initial begin
      ap_rst_n = 1'b0;
      awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;

      #23;
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rlast", rlast, 0);
      #4 ap_rst_n = 1'b1;
      #1 chk("rel_awready_early", awready, 0);
      tick;
      chk("rel_awready", awready, 1);
      chk("rel_arready", arready, 1);

      // 4-beat INCR write then readback
      for (int i = 0; i < 4; i++) begin
         wdat[i] = 32'hA0 + i;
         rexp[i] = 32'hA0 + i;
      end
      do_write(64'h100, 8'd3, 2'b01, 1'b1, 3, 4'hF, 2'b00);
      do_read(64'h100, 8'd3, 2'b01, 1'b1, 2'b00, -1);

      // byte strobes on the same word
      wdat[0] = 32'hFFFF_FFFF;
      do_write(64'h200, 8'd0, 2'b01, 1'b0, 0, 4'hF, 2'b00);
      wdat[0] = 32'h1122_3344;
      do_write(64'h200, 8'd0, 2'b01, 1'b0, 0, 4'h5, 2'b00);
      rexp[0] = 32'hFF22_FF44;
      do_read(64'h200, 8'd0, 2'b01, 1'b0, 2'b00, -1);

      // back-pressure mid-burst
      for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + i;
      do_read(64'h100, 8'd3, 2'b01, 1'b0, 2'b00, 1);

      // error responses
      wdat[0] = 32'h0BAD_0001;
      do_write(64'h300, 8'd0, 2'b00, 1'b1, 0, 4'hF, 2'b10);
      for (int i = 0; i < 4; i++) wdat[i] = 32'hC0 + i;
      do_write(64'h310, 8'd3, 2'b01, 1'b0, 1, 4'hF, 2'b10);
      for (int i = 0; i < 4; i++) rexp[i] = 32'hA0 + i;
      do_read(64'h100, 8'd3, 2'b10, 1'b1, 2'b10, -1);

      // index wrap 1023 -> 0, high address bits ignored
      wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222;
      do_write(64'hFFC, 8'd1, 2'b01, 1'b1, 1, 4'hF, 2'b00);
      rexp[0] = 32'h2222_2222;
      do_read(64'h0, 8'd0, 2'b01, 1'b0, 2'b00, -1);
      rexp[0] = 32'h1111_1111; rexp[1] = 32'h2222_2222;
      do_read(64'h8000_0000_0000_0FFC, 8'd1, 2'b01, 1'b0, 2'b00, -1);

      // same-edge write and read of one word, channels concurrently active
      wdat[0] = 32'h1234_5678;
      do_write(64'h600, 8'd0, 2'b01, 1'b0, 0, 4'hF, 2'b00);
      awvalid = 1'b1; awaddr = 64'h600; awlen = 0; awburst = 2'b01; awid = 0;
      tick;
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1;
      arvalid = 1'b1; araddr = 64'h600; arlen = 0; arburst = 2'b01; arid = 1;
      bready = 1'b1;
      chk("conc_wready", wready, 1);
      chk("conc_arready", arready, 1);
      tick;
      wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
      chk("conc_rvalid", rvalid, 1);
      chk("conc_old_data", rdata, 32'h1234_5678);
      chk("conc_bvalid", bvalid, 1);
      rready = 1'b1;
      tick;
      bready = 1'b0; rready = 1'b0;
      chk("conc_idle", {bvalid, rvalid}, 2'b00);
      rexp[0] = 32'hCAFE_F00D;
      do_read(64'h600, 8'd0, 2'b01, 1'b0, 2'b00, -1);

      // reset in the middle of a write burst
      awvalid = 1'b1; awaddr = 64'h500; awlen = 3; awburst = 2'b01; awid = 1;
      tick;
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = 32'hDEAD_0000; wstrb = 4'hF; wlast = 1'b0;
      tick;
      chk("mid_wready", wready, 1);
      ap_rst_n = 1'b0;
      #1;
      chk("mid_rst_wready", wready, 0);
      chk("mid_rst_awready", awready, 0);
      chk("mid_rst_arready", arready, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_bid", bid, 0);
      wvalid = 1'b0;
      #3 ap_rst_n = 1'b1;
      tick;
      for (int i = 0; i < 2; i++) wdat[i] = 32'h5500 + i;
      do_write(64'h500, 8'd1, 2'b01, 1'b1, 1, 4'hF, 2'b00);
      for (int i = 0; i < 2; i++) rexp[i] = 32'h5500 + i;
      do_read(64'h500, 8'd1, 2'b01, 1'b1, 2'b00, -1);
      rexp[0] = 32'hFF22_FF44;
      do_read(64'h200, 8'd0, 2'b01, 1'b0, 2'b00, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: AW/AR address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 1; parameter DEPTH_LOG2, default 10: memory holds 2^DEPTH_LOG2 words.
REQ-004 ap_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 s_axi_a_AWVALID  in  1  write address valid.
REQ-007 s_axi_a_AWREADY  out  1  write address accepted.
REQ-008 s_axi_a_AWADDR  in  ADDR_WIDTH  byte address of the first beat.
REQ-009 s_axi_a_AWID  in  ID_WIDTH  write transaction ID.
REQ-010 s_axi_a_AWLEN  in  8  beats minus one.
REQ-011 s_axi_a_AWBURST  in  2  burst type.
REQ-012 s_axi_a_WVALID  in  1  write data valid.
REQ-013 s_axi_a_WREADY  out  1  write data accepted.
REQ-014 s_axi_a_WDATA  in  DATA_WIDTH  write data.
REQ-015 s_axi_a_WSTRB  in  DATA_WIDTH/8  byte enables.
REQ-016 s_axi_a_WLAST  in  1  last write beat.
REQ-017 s_axi_a_BVALID  out  1  write response valid.
REQ-018 s_axi_a_BREADY  in  1  write response accepted.
REQ-019 s_axi_a_BRESP  out  2  write response code.
REQ-020 s_axi_a_BID  out  ID_WIDTH  echo of the latched AWID.
REQ-021 s_axi_a_ARVALID  in  1  read address valid.
REQ-022 s_axi_a_ARREADY  out  1  read address accepted.
REQ-023 s_axi_a_ARADDR  in  ADDR_WIDTH  byte address of the first beat.
REQ-024 s_axi_a_ARID  in  ID_WIDTH  read transaction ID.
REQ-025 s_axi_a_ARLEN  in  8  beats minus one.
REQ-026 s_axi_a_ARBURST  in  2  burst type.
REQ-027 s_axi_a_RVALID  out  1  read data valid.
REQ-028 s_axi_a_RREADY  in  1  read data accepted.
REQ-029 s_axi_a_RDATA  out  DATA_WIDTH  read data.
REQ-030 s_axi_a_RLAST  out  1  last read beat.
REQ-031 s_axi_a_RID  out  ID_WIDTH  echo of the latched ARID.
REQ-032 s_axi_a_RRESP  out  2  read response code.

Function
REQ-033 SHALL run independent write FSM (W_IDLE->W_DATA->W_RESP->W_IDLE) and read FSM (R_IDLE->R_DATA->R_IDLE); one outstanding transaction per direction. AWSIZE/ARSIZE are not ports; every beat is full width.
REQ-034 Word index SHALL be addr[DEPTH_LOG2+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; it increments by 1 per beat and wraps modulo 2^DEPTH_LOG2; high address bits are ignored.
REQ-035 Write: AWREADY=1 only in W_IDLE; on AW handshake latch index, AWLEN, AWID, AWBURST, clear beat count, go to W_DATA.
REQ-036 W_DATA: WREADY=1; each W handshake writes the bytes of WDATA whose WSTRB bit is 1, increments index and count; the beat with count==latched AWLEN goes to W_RESP on the next cycle.
REQ-037 W_RESP: BVALID=1 and BID=latched ID; BRESP=2'b10 if AWBURST!=INCR (2'b01) or WLAST did not coincide exactly with the final beat, else 2'b00; a BREADY handshake returns the FSM to W_IDLE.
REQ-038 Read: ARREADY=1 only in R_IDLE; an AR handshake latches index, ARLEN, ARID, ARBURST and registers RDATA=mem[index]; RVALID rises on the cycle after the handshake (latency 1).
REQ-039 R_DATA: RDATA, RLAST and RID SHALL hold stable while RVALID=1 and RREADY=0; each R handshake registers the next word; RLAST=1 on beat AWLEN-equivalent count==ARLEN; the handshake with RLAST=1 returns the FSM to R_IDLE with RVALID=0.
REQ-040 RRESP SHALL be 2'b10 on every beat when ARBURST!=INCR, else 2'b00; non-INCR bursts are still addressed as INCR.
REQ-041 When a write to index k and a read of index k occur on the same edge, the read SHALL return the pre-write data.
REQ-042 SHALL be throughput one beat per cycle in each direction, and concurrent reads and writes SHALL NOT stall each other.

Reset
REQ-043 ap_rst_n=0 SHALL immediately force both FSMs idle and all outputs to 0 (including AWREADY, ARREADY, BRESP, RDATA), abandoning any burst in flight; already-written memory words are retained, memory is not initialised by reset, and AWREADY/ARREADY rise one cycle after deassertion.

Verification
REQ-044 AW addr 0x100, AWLEN=3, INCR; W 0xA0..0xA3, WSTRB=0xF, WLAST on beat 3 -> one BVALID, BRESP=00, BID=AWID; AR addr 0x100, len 3 -> RDATA A0,A1,A2,A3, RLAST on beat 3 only.
REQ-045 Write 0xFFFFFFFF then 0x11223344 with WSTRB=0x5 to the same word -> readback 0xFF22FF44.
REQ-046 RREADY held low 5 cycles mid-burst -> RDATA/RLAST stable; no beat lost or duplicated.
REQ-047 AWBURST=FIXED, or WLAST asserted on beat 1 of a 4-beat burst -> BRESP=10; ARBURST=WRAP -> RRESP=10 on all beats.
REQ-048 Burst starting at word 1023 (DEPTH_LOG2=10), len 1 -> second beat at word 0; ap_rst_n pulsed low mid-burst -> all outputs 0 immediately, then a new AW is accepted normally.
